// File: rtl/clk_div_ctrl.sv
// Programmable integer clock divider with handshaked ratio changes applied at period boundaries.
// Optional completed-period counter on per_cnt is built only with CLK_DIV_CTRL_PERCNT_EN defined.
module clk_div_ctrl #(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DIV_RST = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             busy,
    output logic             clk_out,
    output logic             clkb_out,
    output logic             tick,
    output logic [15:0]      per_cnt
);

    localparam logic [DIV_W-1:0] NRst = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] NMin = DIV_W'(2);

    typedef enum logic [1:0] {StOff, StRun, StPend} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] n_q, n_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             clkb_out_q;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic cnt_last;
    logic req_ok;
    logic req_bad;
    logic load;
    logic run_d;

    assign cnt_last = (cnt_q == n_q - 1'b1);
    // Requests are only looked at while no change is pending.
    assign req_ok   = div_req && (state_q != StPend) && (div_val >= NMin);
    assign req_bad  = div_req && (state_q != StPend) && (div_val < NMin);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        pend_d  = pend_q;
        load    = 1'b0;
        unique case (state_q)
            StOff: begin
                // Load before starting so the first period already uses the new ratio.
                if (req_ok) begin
                    n_d  = div_val;
                    load = 1'b1;
                end
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last && !en) begin
                    // Stopping at a boundary: no period left to defer to, so load now.
                    state_d = StOff;
                    if (req_ok) begin
                        n_d  = div_val;
                        load = 1'b1;
                    end
                end else if (req_ok) begin
                    pend_d  = div_val;
                    state_d = StPend;
                end
            end
            StPend: begin
                cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last) begin
                    n_d     = pend_q;
                    load    = 1'b1;
                    state_d = en ? StRun : StOff;
                end
            end
            default: begin
                state_d = StOff;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are derived from next-state values so they register with no output logic.
    always_comb begin
        run_d     = (state_d != StOff);
        clk_out_d = run_d && (cnt_d < (n_d >> 1));
        tick_d    = run_d && (cnt_d == '0);
        busy_d    = (state_d == StPend);
        ack_d     = load | req_bad;
        err_d     = req_bad;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= StOff;
            cnt_q      <= '0;
            n_q        <= NRst;
            pend_q     <= '0;
            clk_out_q  <= 1'b0;
            clkb_out_q <= 1'b1;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            clkb_out_q <= ~clk_out_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign clk_out  = clk_out_q;
    assign clkb_out = clkb_out_q;
    assign tick     = tick_q;
    assign div_ack  = ack_q;
    assign div_err  = err_q;
    assign busy     = busy_q;

`ifdef CLK_DIV_CTRL_PERCNT_EN
    logic        wrap;
    logic [15:0] per_q, per_d;

    assign wrap = (state_q != StOff) && cnt_last;

    always_comb begin
        per_d = per_q;
        if (load) begin
            per_d = '0;
        end else if (wrap && (per_q != 16'hFFFF)) begin
            per_d = per_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            per_q <= '0;
        end else begin
            per_q <= per_d;
        end
    end

    assign per_cnt = per_q;
`else
    assign per_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed vector table, hand sequences, and randomized run vs a model.
module tb_clk_div_ctrl;

    localparam int DW   = 8;
    localparam int DRST = 2;
`ifdef CLK_DIV_CTRL_PERCNT_EN
    localparam bit PerEn = 1'b1;
`else
    localparam bit PerEn = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          div_req = 1'b0;
    logic [DW-1:0] div_val = '0;
    logic          div_ack, div_err, busy, clk_out, clkb_out, tick;
    logic [15:0]   per_cnt;

    always #5 clk_in = ~clk_in;

    clk_div_ctrl #(
        .DIV_W  (DW),
        .DIV_RST(DRST)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .div_req (div_req),
        .div_val (div_val),
        .div_ack (div_ack),
        .div_err (div_err),
        .busy    (busy),
        .clk_out (clk_out),
        .clkb_out(clkb_out),
        .tick    (tick),
        .per_cnt (per_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: position within the current period, active ratio, pending-ratio queue.
    bit m_on;
    int m_pos, m_n, m_per;
    int m_pend[$];
    bit m_ack, m_err;

    function automatic void model_step(bit r, bit e, bit q, int v);
        bit was_on, eop, accept;
        m_ack = 1'b0;
        m_err = 1'b0;
        if (r) begin
            m_on = 1'b0; m_pos = 0; m_n = DRST; m_per = 0;
            m_pend.delete();
            return;
        end
        was_on = m_on;
        accept = (m_pend.size() == 0);
        eop    = m_on && (m_pos == m_n - 1);
        if (m_on) begin
            if (eop) begin
                if (m_per < 65535) m_per++;
                m_pos = 0;
                if (m_pend.size() != 0) begin
                    m_n = m_pend.pop_front();
                    m_per = 0;
                    m_ack = 1'b1;
                end
                if (!e) m_on = 1'b0;
            end else begin
                m_pos++;
            end
        end
        if (accept && q) begin
            if (v < 2) begin
                m_ack = 1'b1;
                m_err = 1'b1;
            end else if (!was_on || (eop && !e)) begin
                m_n = v; m_per = 0; m_ack = 1'b1;
            end else begin
                m_pend.push_back(v);
            end
        end
        if (!was_on && e) begin
            m_on = 1'b1;
            m_pos = 0;
        end
    endfunction

    task automatic check(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic compare_model();
        bit e_clk;
        e_clk = m_on && (m_pos < m_n / 2);
        check("model clk_out", int'(clk_out), int'(e_clk));
        check("model clkb_out", int'(clkb_out), int'(!e_clk));
        check("model tick", int'(tick), int'(m_on && m_pos == 0));
        check("model div_ack", int'(div_ack), int'(m_ack));
        check("model div_err", int'(div_err), int'(m_err));
        check("model busy", int'(busy), int'(m_pend.size() != 0));
        check("model per_cnt", int'(per_cnt), PerEn ? m_per : 0);
    endtask

    task automatic apply(bit r, bit e, bit q, int v);
        rst = r; en = e; div_req = q; div_val = DW'(v);
        @(posedge clk_in);
        #1;
        cyc++;
        model_step(r, e, q, v);
        compare_model();
    endtask

    typedef struct {
        bit rst, en, req;
        int val;
        bit clk, tck, ack, err, bsy;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit r, bit e, bit q, int v, bit c, bit t, bit a, bit er, bit b);
        vec_t x;
        x.rst = r; x.en = e; x.req = q; x.val = v;
        x.clk = c; x.tck = t; x.ack = a; x.err = er; x.bsy = b;
        tbl.push_back(x);
    endfunction

    initial begin
        bit en_r;
        // reset, then N=2 toggling
        add(1,0,0,0, 0,0,0,0,0);
        add(0,1,0,0, 1,1,0,0,0); add(0,1,0,0, 0,0,0,0,0);
        add(0,1,0,0, 1,1,0,0,0); add(0,1,0,0, 0,0,0,0,0);
        // change to N=4 at a boundary: pending for one full N=2 period
        add(0,1,1,4, 1,1,0,0,1); add(0,1,0,0, 0,0,0,0,1); add(0,1,0,0, 1,1,1,0,0);
        add(0,1,0,0, 1,0,0,0,0); add(0,1,0,0, 0,0,0,0,0); add(0,1,0,0, 0,0,0,0,0);
        add(0,1,0,0, 1,1,0,0,0);
        // N=4 -> 6 requested entering cnt=1; second request while busy is ignored
        add(0,1,1,6, 1,0,0,0,1); add(0,1,1,9, 0,0,0,0,1); add(0,1,0,0, 0,0,0,0,1);
        add(0,1,0,0, 1,1,1,0,0); add(0,1,0,0, 1,0,0,0,0); add(0,1,0,0, 1,0,0,0,0);
        add(0,1,0,0, 0,0,0,0,0); add(0,1,0,0, 0,0,0,0,0); add(0,1,0,0, 0,0,0,0,0);
        add(0,1,0,0, 1,1,0,0,0);
        // illegal ratio 1: ack+err, period unchanged
        add(0,1,1,1, 1,0,1,1,0); add(0,1,0,0, 1,0,0,0,0); add(0,1,0,0, 0,0,0,0,0);
        add(0,1,0,0, 0,0,0,0,0); add(0,1,0,0, 0,0,0,0,0); add(0,1,0,0, 1,1,0,0,0);
        // stop, load N=5 while off, restart, stop at cnt=2
        add(0,0,0,0, 1,0,0,0,0); add(0,0,0,0, 1,0,0,0,0); add(0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0); add(0,0,0,0, 0,0,0,0,0); add(0,0,0,0, 0,0,0,0,0);
        add(0,0,1,5, 0,0,1,0,0); add(0,1,0,0, 1,1,0,0,0); add(0,1,0,0, 1,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0); add(0,0,0,0, 0,0,0,0,0); add(0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0); add(0,0,0,0, 0,0,0,0,0);

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].val);
            check($sformatf("tbl[%0d] clk_out", i), int'(clk_out), int'(tbl[i].clk));
            check($sformatf("tbl[%0d] clkb_out", i), int'(clkb_out), int'(!tbl[i].clk));
            check($sformatf("tbl[%0d] tick", i), int'(tick), int'(tbl[i].tck));
            check($sformatf("tbl[%0d] div_ack", i), int'(div_ack), int'(tbl[i].ack));
            check($sformatf("tbl[%0d] div_err", i), int'(div_err), int'(tbl[i].err));
            check($sformatf("tbl[%0d] busy", i), int'(busy), int'(tbl[i].bsy));
        end

        // reset during a pending change drops it silently
        apply(1,0,0,0); apply(0,1,0,0); apply(0,1,1,7);
        check("pend busy", int'(busy), 1);
        apply(1,1,0,0);
        check("rst busy", int'(busy), 0);
        check("rst ack", int'(div_ack), 0);
        check("rst clk_out", int'(clk_out), 0);
        check("rst clkb_out", int'(clkb_out), 1);
        check("rst tick", int'(tick), 0);
        check("rst per_cnt", int'(per_cnt), 0);
        apply(0,0,0,0);
        check("post-rst ack", int'(div_ack), 0);
        apply(0,1,0,0);
        check("post-rst start", int'(clk_out), 1);
        apply(0,1,0,0);
        check("post-rst N=2", int'(clk_out), 0);

        // ten N=2 periods, then a ratio load clears the period count
        apply(1,0,0,0);
        for (int i = 0; i < 21; i++) apply(0,1,0,0);
        check("per_cnt 10 periods", int'(per_cnt), PerEn ? 10 : 0);
        apply(0,1,1,3);
        check("per_cnt while pending", int'(per_cnt), PerEn ? 10 : 0);
        apply(0,1,0,0);
        check("load ack", int'(div_ack), 1);
        check("per_cnt cleared", int'(per_cnt), 0);

        // randomized run against the model
        apply(1,0,0,0);
        en_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) en_r = !en_r;
            apply($urandom_range(0, 399) == 0, en_r, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 12));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
